// File: rtl/lut_pkg.sv
// Shared constants, FSM state type and checksum helper for the rd_8 weight
// table loader slice.
package lut_pkg;

  localparam int DW    = 24;         // weight width, multiple of 8
  localparam int AW    = 8;          // table address width
  localparam int DEPTH = 1 << AW;    // table entries
  localparam int BPW   = DW / 8;     // bytes per weight
  localparam int SW    = DW - 8;     // shift register width (bytes held before the last)
  localparam int BI_W  = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } lut_state_e;

  // Modulo-256 running sum used by the optional trailing checksum.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

endpackage

// File: rtl/lut_wr_8_loader_if.sv
// Byte-stream load handshake plus the combinational table read port.
interface lut_wr_8_loader_if;
  import lut_pkg::*;

  logic          i_start;
  logic          i_byte_valid;
  logic [7:0]    i_byte;
  logic          o_byte_ready;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic [AW-1:0] i_rd_addr;
  logic [DW-1:0] o_rd_dout;

  // Host / stimulus side.
  modport master (
    output i_start, i_byte_valid, i_byte, i_rd_addr,
    input  o_byte_ready, o_busy, o_done, o_err, o_rd_dout
  );

  // Loader side.
  modport slave (
    input  i_start, i_byte_valid, i_byte, i_rd_addr,
    output o_byte_ready, o_busy, o_done, o_err, o_rd_dout
  );

endinterface

// File: rtl/lut_ram_dp.sv
// DEPTH x DW table: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module lut_ram_dp #(
  parameter int DW    = 24,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem_r [DEPTH];

  // Write one packed weight per strobe.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_r[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_r[i_raddr];

endmodule

// File: rtl/lut_wr_8_loader.sv
// Runtime loader for the rd_8 weight table: packs an MSB-first byte stream
// into DW-bit weights and writes them to addresses 0..DEPTH-1 in order.
// Optional feature macro: LUT_WR_CHECKSUM_EN adds a trailing modulo-256
// checksum byte and drives o_err on mismatch.
module lut_wr_8_loader
  import lut_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  lut_wr_8_loader_if.slave   bus
);

`ifdef LUT_WR_CHECKSUM_EN
  localparam lut_state_e LOAD_EXIT = CHECK;
`else
  localparam lut_state_e LOAD_EXIT = DONE;
`endif

  lut_state_e      state_r;
  lut_state_e      state_nxt_s;
  logic [BI_W-1:0] byte_idx_r;
  logic [AW-1:0]   addr_r;
  logic [SW-1:0]   shift_r;
  logic            ready_r;
  logic            busy_r;
  logic            done_r;

  logic            accept_s;
  logic            last_byte_s;
  logic            last_word_s;
  logic            we_s;
  logic [DW-1:0]   wdata_s;
  logic [SW+7:0]   shift_cat_s;
  logic            busy_nxt_s;
  logic            done_nxt_s;

  // Handshake qualification; a start pulse wins over a simultaneous byte.
  always_comb begin
    accept_s    = bus.i_byte_valid & ready_r & ~bus.i_start;
    last_byte_s = (byte_idx_r == BI_W'(BPW - 1));
    last_word_s = (addr_r == AW'(DEPTH - 1));
    we_s        = accept_s & (state_r == LOAD) & last_byte_s;
    wdata_s     = {shift_r, bus.i_byte};
    shift_cat_s = {shift_r, bus.i_byte};
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.i_start) state_nxt_s = LOAD;
        else             state_nxt_s = IDLE;
      end
      LOAD: begin
        if (bus.i_start)                                 state_nxt_s = LOAD;
        else if (accept_s && last_byte_s && last_word_s) state_nxt_s = LOAD_EXIT;
        else                                             state_nxt_s = LOAD;
      end
`ifdef LUT_WR_CHECKSUM_EN
      CHECK: begin
        if (bus.i_start)   state_nxt_s = LOAD;
        else if (accept_s) state_nxt_s = DONE;
        else               state_nxt_s = CHECK;
      end
`endif
      DONE: begin
        if (bus.i_start) state_nxt_s = LOAD;
        else             state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output decode, taken from the next state so the flags are registered.
  always_comb begin
    busy_nxt_s = (state_nxt_s == LOAD) || (state_nxt_s == CHECK);
    done_nxt_s = (state_nxt_s == DONE);
  end

  // Registered status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      ready_r <= busy_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Byte index, word address and partial-word shift register.
  always_ff @(posedge i_clk) begin
    if (i_rst || bus.i_start) begin
      byte_idx_r <= '0;
      addr_r     <= '0;
      shift_r    <= '0;
    end else if (accept_s && (state_r == LOAD)) begin
      if (last_byte_s) begin
        byte_idx_r <= '0;
        if (!last_word_s) addr_r <= addr_r + AW'(1);
        else              addr_r <= addr_r;
      end else begin
        byte_idx_r <= byte_idx_r + BI_W'(1);
        shift_r    <= shift_cat_s[SW-1:0];
      end
    end else begin
      byte_idx_r <= byte_idx_r;
      addr_r     <= addr_r;
      shift_r    <= shift_r;
    end
  end

`ifdef LUT_WR_CHECKSUM_EN
  logic [7:0] sum_r;
  logic       err_r;

  // Running sum of data bytes and the compare against the trailing byte.
  always_ff @(posedge i_clk) begin
    if (i_rst || bus.i_start) begin
      sum_r <= 8'h00;
      err_r <= 1'b0;
    end else if (accept_s && (state_r == LOAD)) begin
      sum_r <= csum_add(sum_r, bus.i_byte);
    end else if (accept_s && (state_r == CHECK)) begin
      err_r <= (sum_r != bus.i_byte);
    end else begin
      sum_r <= sum_r;
      err_r <= err_r;
    end
  end

  assign bus.o_err = err_r;
`else
  assign bus.o_err = 1'b0;
`endif

  assign bus.o_byte_ready = ready_r;
  assign bus.o_busy       = busy_r;
  assign bus.o_done       = done_r;

  lut_ram_dp #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (we_s),
    .i_waddr (addr_r),
    .i_wdata (wdata_s),
    .i_raddr (bus.i_rd_addr),
    .o_rdata (bus.o_rd_dout)
  );

endmodule

// File: tb/tb_lut_wr_8_loader.sv
// Scoreboard bench for lut_wr_8_loader: stimulus pushes expected load
// completions and readbacks into a queue; a negedge monitor pops and compares.
module tb_lut_wr_8_loader;
  import lut_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lut_wr_8_loader_if bus_if();

  lut_wr_8_loader dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  typedef struct {
    bit          is_done;
    logic [23:0] exp_val;
    logic [7:0]  addr;
    bit          exp_err;
    int          exp_elapsed;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   first_acc = 0;
  bit   need_first = 1'b0;
  bit   rd_req = 1'b0;
  logic done_prev = 1'b0;

`ifdef LUT_WR_CHECKSUM_EN
  localparam int LOAD_CYCLES = 769;
`else
  localparam int LOAD_CYCLES = 768;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] pat(input logic [7:0] n, input logic [7:0] s);
    return {n ^ s, (~n) ^ s, n ^ 8'h5A};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic abort(input string nm);
    errors++;
    checks++;
    $display("FAIL %s: timeout", nm);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "aborted");
  endtask

  // Monitor: compares every readback request and every rising o_done.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_req) begin
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          errors++;
          checks++;
          $display("FAIL rd_order: got readback with no matching expectation, expected %0d", 1);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rd[%02h]", e.addr), 32'(bus_if.o_rd_dout), 32'(e.exp_val));
        end
      end
      if (bus_if.o_done === 1'b1 && done_prev !== 1'b1) begin
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          errors++;
          checks++;
          $display("FAIL done_order: got unexpected o_done rise, expected %0d", 0);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          e = exp_q.pop_front();
          chk("done_err", 32'(bus_if.o_err), 32'(e.exp_err));
          if (e.exp_elapsed > 0) chk("load_cycles", 32'(cyc - first_acc + 1), 32'(e.exp_elapsed));
        end
      end
      done_prev = bus_if.o_done;
    end
  end

  initial begin : watchdog
    #1_000_000;
    abort("global_watchdog");
  end

  task automatic expect_done(input bit err, input int elapsed);
    exp_t e;
    e.is_done = 1'b1; e.exp_val = 24'h0; e.addr = 8'h00;
    e.exp_err = err; e.exp_elapsed = elapsed;
    exp_q.push_back(e);
  endtask

  task automatic rd(input logic [7:0] a, input logic [23:0] ev);
    exp_t e;
    e.is_done = 1'b0; e.exp_val = ev; e.addr = a;
    e.exp_err = 1'b0; e.exp_elapsed = 0;
    exp_q.push_back(e);
    bus_if.i_rd_addr = a;
    rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic check_all(input logic [7:0] s);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = 8'(i);
      rd(a, pat(a, s));
    end
  endtask

  task automatic chk_ctrl(input string nm, input bit exp_busy, input bit exp_ready, input bit exp_done);
    @(negedge clk);
    chk({nm, "_busy"},  32'(bus_if.o_busy),       32'(exp_busy));
    chk({nm, "_ready"}, 32'(bus_if.o_byte_ready), 32'(exp_ready));
    chk({nm, "_done"},  32'(bus_if.o_done),       32'(exp_done));
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    bus_if.i_start = 1'b1;
    @(posedge clk); #1;
    bus_if.i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps && $urandom_range(0, 1) == 1) begin
      bus_if.i_byte_valid = 1'b0;
      bus_if.i_byte = 8'h00;
      @(posedge clk); #1;
    end
    bus_if.i_byte_valid = 1'b1;
    bus_if.i_byte = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus_if.o_byte_ready === 1'b1) break;
      n++;
      if (n > 20) abort("byte_accept");
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (need_first) begin
      first_acc = cyc;
      need_first = 1'b0;
    end
  endtask

  // Sends nbytes of pattern s; a full load also gets the checksum byte when enabled.
  task automatic stream(input logic [7:0] s, input bit gaps, input int nbytes, input bit ck_bad);
    logic [7:0]  sum;
    logic [7:0]  b;
    logic [23:0] w;
    int          q;
    sum = 8'h00;
    need_first = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      q = i / 3;
      w = pat(q[7:0], s);
      case (i % 3)
        0:       b = w[23:16];
        1:       b = w[15:8];
        default: b = w[7:0];
      endcase
      sum = sum + b;
      send_byte(b, gaps);
    end
    if (ck_bad) sum = sum + 8'h01;
`ifdef LUT_WR_CHECKSUM_EN
    if (nbytes == 768) send_byte(sum, gaps);
`endif
    bus_if.i_byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus_if.o_done === 1'b1) break;
      n++;
      if (n > 3000) abort("wait_done");
    end
    @(posedge clk); #1;
  endtask

  initial begin : stim
    rst = 1'b1;
    bus_if.i_start = 1'b0;
    bus_if.i_byte_valid = 1'b0;
    bus_if.i_byte = 8'h00;
    bus_if.i_rd_addr = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, then valid bytes in IDLE are not taken.
    @(negedge clk);
    chk("rst_err", 32'(bus_if.o_err), 32'd0);
    @(posedge clk); #1;
    chk_ctrl("rst", 1'b0, 1'b0, 1'b0);
    bus_if.i_byte_valid = 1'b1;
    bus_if.i_byte = 8'hC7;
    chk_ctrl("idle_valid", 1'b0, 1'b0, 1'b0);
    bus_if.i_byte_valid = 1'b0;

    // Full gapless load of the reference pattern; cycle count checked.
    pulse_start();
    chk_ctrl("start", 1'b1, 1'b1, 1'b0);
    expect_done(1'b0, LOAD_CYCLES);
    stream(8'h00, 1'b0, 768, 1'b0);
    wait_done();
    chk_ctrl("after_done", 1'b0, 1'b0, 1'b1);
    rd(8'h10, 24'h10EF4A);
    rd(8'hFF, 24'hFF00A5);
    rd(8'h00, 24'h00FF5A);

    // Valid bytes in DONE are ignored; memory keeps the prior load.
    bus_if.i_byte_valid = 1'b1;
    bus_if.i_byte = 8'hAA;
    repeat (4) chk_ctrl("done_valid", 1'b0, 1'b0, 1'b1);
    bus_if.i_byte_valid = 1'b0;
    check_all(8'h00);

    // Gapped load of a new pattern.
    pulse_start();
    chk_ctrl("restart_from_done", 1'b1, 1'b1, 1'b0);
    expect_done(1'b0, 0);
    stream(8'h33, 1'b1, 768, 1'b0);
    wait_done();
    check_all(8'h33);

    // Reset mid-load, then a clean reload.
    pulse_start();
    stream(8'h5C, 1'b0, 100, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_ctrl("mid_rst", 1'b0, 1'b0, 1'b0);
    pulse_start();
    expect_done(1'b0, 0);
    stream(8'h71, 1'b0, 768, 1'b0);
    wait_done();
    check_all(8'h71);

    // Restart after 301 bytes with a byte offered on the start cycle.
    pulse_start();
    stream(8'hC3, 1'b0, 301, 1'b0);
    bus_if.i_byte_valid = 1'b1;
    bus_if.i_byte = 8'hEE;
    pulse_start();
    bus_if.i_byte_valid = 1'b0;
    chk_ctrl("mid_restart", 1'b1, 1'b1, 1'b0);
    expect_done(1'b0, 0);
    stream(8'h96, 1'b0, 768, 1'b0);
    wait_done();
    check_all(8'h96);

`ifdef LUT_WR_CHECKSUM_EN
    // Corrupted checksum flags o_err; the next start clears it.
    pulse_start();
    expect_done(1'b1, 0);
    stream(8'h0F, 1'b0, 768, 1'b1);
    wait_done();
    rd(8'h10, pat(8'h10, 8'h0F));
    pulse_start();
    @(negedge clk);
    chk("err_cleared", 32'(bus_if.o_err), 32'd0);
    @(posedge clk); #1;
    expect_done(1'b0, 0);
    stream(8'h0F, 1'b0, 768, 1'b0);
    wait_done();
    rd(8'hFF, pat(8'hFF, 8'h0F));
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
